arm_mc_ctrl_ls: RTL and testbench
=================================

# arm_mc_ctrl_ls

Parametrised multi-cycle control unit for the ARM-subset CPU. It adds LDR/STR (immediate offset) to data-processing, B, BL and BX, with ready/handshake waits on instruction and data memory. A programmable wait-timeout leads to an abort trap, and undefined instructions take a trap vector. It sits between the instruction register and the existing datapath (register file, ALU/shifter, PC unit) and drives all of their load/select strobes.

## Interface
- WAIT_LIMIT, 15: maximum cycles a memory access may wait for ready before the access aborts (≥1).
- TRAP_EN, 1: 1 = undefined instructions and timeouts redirect PC to the trap vector; 0 = they are skipped (refetch).
- clk  in  1  system clock, all state on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- IR  in  32  current instruction word {cond, IR[27:0]}.
- flag  in  1  condition check result for IR[31:28] against NZCV.
- imem_ready  in  1  instruction memory has data valid this cycle.
- dmem_ready  in  1  data memory completed the requested access this cycle.
- Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S  out  1 each  datapath strobes.
- rm_imm_s  out  1  shifter data = imm8 (1) or Rm (0).
- rs_imm_s  out  2  shift amount: 00 imm5, 01 Rs[7:0], 10 rot imm.
- PC_s  out  2  PC source: 00 PC+4, 01 Rm (BX), 10 F, 11 trap vector.
- rd_s, ALU_A_s, ALU_B_s  out  1 each  W_Addr=R14 / A=PC / B=imm24 offset.
- off_s  out  1  ALU B operand = zero-extended imm12 (load/store offset).
- wb_s  out  1  register write data = dmem read data (1) or F (0).
- ALU_OP  out  4  ALU operation.
- imem_req, dmem_req, dmem_we  out  1 each  memory requests.
- und_trap, abort  out  1 each  one-cycle event pulses.

## Operation
- Decode classes: DP0 (000, IR[4]=0), DP1 (000, IR[4]=1, IR[7]=0), DP2 (001), BX (IR[27:4]=0x12FFF1), B/BL (101, IR[24]), LS (IR[27:25]=010, P=1, W=0). Everything else, including LS with P=0 or W=1, is Und.
- States: IDLE, FETCH, DECODE, EXEC, WB, BXW, BADD, BLNK, BJMP, LSADDR, LDWAIT, LDWB, STWAIT, TRAP.
- IDLE → FETCH.
- FETCH holds imem_req=1 until imem_ready. The ready cycle pulses Write_PC and Write_IR (PC_s=00).
- After a fetch, branch on the instruction:
  - flag=0 → FETCH again.
  - Und → TRAP if TRAP_EN, else FETCH.
  - B → BADD.
  - BL → BLNK.
  - Any other valid instruction → DECODE.
- DECODE: LA=LB=LC=1. Next state is BXW (BX), LSADDR (LS) or EXEC.
- EXEC: LF=1, S=IR[20], rm_imm_s=class DP2, rs_imm_s=class code.
  - ALU_OP=OP, except OP=1000/1001/1010/1011 map to 0000/0001/0010/0100.
  - Next state is WB.
- WB: Write_Reg = !OP[3] | OP[2].
- BXW: Write_PC with PC_s=01.
- BADD: ALU_A_s=ALU_B_s=1, ALU_OP=0100, LF=1, then BJMP.
- BLNK: ALU_A_s=1, ALU_OP=1000, LF=1, then BJMP. In BJMP, Write_Reg=1 and rd_s=1 commit the link; the re-latched F (ALU_A_s=ALU_B_s=1, ALU_OP=0100, LF=1) then takes one extra BJMP pass with Write_PC, PC_s=10.
- BJMP: Write_PC, PC_s=10.
- LSADDR: off_s=1, LF=1, ALU_OP = 0100 if U(IR[23]) else 0010. Next state is LDWAIT if L(IR[20]) else STWAIT.
- LDWAIT/STWAIT: dmem_req=1, dmem_we=!L.
  - On dmem_ready, LDWAIT → LDWB and STWAIT → FETCH.
  - LDWB: Write_Reg=1, wb_s=1.
- Wait counter: clears on entry to any wait state and increments per stalled cycle. When it reaches WAIT_LIMIT without ready, abort pulses and the next state is TRAP (TRAP_EN) or FETCH.
- TRAP: Write_PC with PC_s=11, then FETCH.
- und_trap pulses on entry to TRAP from Und.
- A ready arriving in the same cycle the counter hits WAIT_LIMIT counts as success.

## Timing
- All outputs are registered and decoded from Next_ST, so strobes appear in the cycle the FSM occupies that state.
- Reset values: every output 0, ST=IDLE, wait counter 0. Rst asserted mid-access drops dmem_req/imem_req on the next edge. No Write_* fires after Rst.
- Cycles counted from fetch, with zero-wait memories:
  - DP: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BX: 3 cycles.
  - B: 3 cycles.
  - BL: 4 cycles.
  - LDR: 5 cycles + wait.
  - STR: 4 cycles + wait.
  - Failed condition: 1 cycle.
- ALU_OP, rm_imm_s and rs_imm_s hold their value outside EXEC/BADD/BLNK/LSADDR.
- Wait counter width = $clog2(WAIT_LIMIT+1).

## Structure
- Shared package arm_ctrl_pkg holds:
  - state enum;
  - decode class enum;
  - PC_s encodings;
  - ALU_OP constants (AND 0000, EOR 0001, SUB 0010, ADD 0100, MOV-pass 1000).
- One sub-module, arm_inst_decode, is natural: combinational class and field extraction from IR.

## Test plan
- ADD r1,r2,r3 (0xE0821003), flag=1, ready=1 → ALU_OP=0100 in EXEC, Write_Reg=1 in WB, 4 cycles total.
- CMP r1,#5 (0xE3510005) → ALU_OP=0010, S=1, Write_Reg stays 0.
- BL +2 (0xEB000002) → BLNK ALU_OP=1000; BJMP rd_s=1, Write_Reg=1, Write_PC with PC_s=10.
- LDR r0,[r1,#8] (0xE5910008), dmem_ready after 3 cycles → dmem_req held 3 cycles, then LDWB with wb_s=1 and Write_Reg=1.
- STR with WAIT_LIMIT=4 and dmem_ready never asserted → abort pulse after 4 wait cycles, TRAP with PC_s=11; with TRAP_EN=0 → FETCH.
- Failed condition (flag=0) and undefined 0xE7F000F0 → immediate refetch / und_trap pulse.
- Rst asserted in LDWAIT → all outputs 0 next edge, no Write_Reg.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM-subset control unit.
package arm_ctrl_pkg;

  // FSM state encodings (kept as plain constants for legacy tooling)
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_WB     = 4'd4;
  localparam logic [3:0] S_BXW    = 4'd5;
  localparam logic [3:0] S_BADD   = 4'd6;
  localparam logic [3:0] S_BLNK   = 4'd7;
  localparam logic [3:0] S_BJMP   = 4'd8;
  localparam logic [3:0] S_LSADDR = 4'd9;
  localparam logic [3:0] S_LDWAIT = 4'd10;
  localparam logic [3:0] S_LDWB   = 4'd11;
  localparam logic [3:0] S_STWAIT = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  typedef enum logic [2:0] {
    CLS_DP0 = 3'd0,
    CLS_DP1 = 3'd1,
    CLS_DP2 = 3'd2,
    CLS_BX  = 3'd3,
    CLS_B   = 3'd4,
    CLS_LS  = 3'd5,
    CLS_UND = 3'd6
  } cls_t;

  localparam logic [1:0] PCS_NEXT = 2'b00;
  localparam logic [1:0] PCS_RM   = 2'b01;
  localparam logic [1:0] PCS_F    = 2'b10;
  localparam logic [1:0] PCS_TRAP = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b1000;

  // Compare/test opcodes reuse the arithmetic/logic ALU op; result is flags only
  function automatic logic [3:0] alu_map(input logic [3:0] op);
    case (op)
      4'b1000: alu_map = ALU_AND;
      4'b1001: alu_map = ALU_EOR;
      4'b1010: alu_map = ALU_SUB;
      4'b1011: alu_map = ALU_ADD;
      default: alu_map = op;
    endcase
  endfunction

endpackage

// File: rtl/arm_inst_decode.sv
// Combinational instruction class and field extraction from IR[27:4].
module arm_inst_decode
  import arm_ctrl_pkg::*;
(
  input  logic [27:4] ir,
  output logic [2:0]  cls,
  output logic [3:0]  op,
  output logic        s_bit,
  output logic        u_bit,
  output logic        l_bit,
  output logic        link
);

  cls_t c;

  // BX is tested first because its encoding also fits the DP1 pattern
  always_comb begin
    c = CLS_UND;
    if (ir[27:4] == 24'h12FFF1)
      c = CLS_BX;
    else if (ir[27:25] == 3'b000 && !ir[4])
      c = CLS_DP0;
    else if (ir[27:25] == 3'b000 && ir[4] && !ir[7])
      c = CLS_DP1;
    else if (ir[27:25] == 3'b001)
      c = CLS_DP2;
    else if (ir[27:25] == 3'b101)
      c = CLS_B;
    else if (ir[27:25] == 3'b010 && ir[24] && !ir[21])
      c = CLS_LS;
  end

  assign cls   = c;
  assign op    = ir[24:21];
  assign s_bit = ir[20];
  assign l_bit = ir[20];
  assign u_bit = ir[23];
  assign link  = ir[24];

endmodule

// File: rtl/arm_mc_ctrl_ls.sv
// Multi-cycle control FSM: DP, B/BL/BX, LDR/STR with memory waits, timeout abort, undefined trap.
module arm_mc_ctrl_ls
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter bit          TRAP_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] IR,
  input  logic        flag,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        Write_PC,
  output logic        Write_IR,
  output logic        Write_Reg,
  output logic        LA,
  output logic        LB,
  output logic        LC,
  output logic        LF,
  output logic        S,
  output logic        rm_imm_s,
  output logic [1:0]  rs_imm_s,
  output logic [1:0]  PC_s,
  output logic        rd_s,
  output logic        ALU_A_s,
  output logic        ALU_B_s,
  output logic        off_s,
  output logic        wb_s,
  output logic [3:0]  ALU_OP,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        und_trap,
  output logic        abort
);

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

  logic [3:0]    st, next_st;
  logic [CW-1:0] wait_cnt, wait_inc;
  logic          link_pend, timeout, und_hit;
  logic          fetch_q, wpc_q;
  logic [2:0]    cls;
  logic [3:0]    op;
  logic          s_bit, u_bit, l_bit, link;
  logic          unused_ir;

  assign unused_ir = ^{IR[31:28], IR[3:0]};

  arm_inst_decode u_dec (
    .ir    (IR[27:4]),
    .cls   (cls),
    .op    (op),
    .s_bit (s_bit),
    .u_bit (u_bit),
    .l_bit (l_bit),
    .link  (link)
  );

  assign wait_inc = wait_cnt + 1'b1;

  // Next-state selection, timeout and undefined-trap detection
  always_comb begin
    next_st = st;
    timeout = 1'b0;
    und_hit = 1'b0;
    case (st)
      S_IDLE: next_st = S_FETCH;
      S_FETCH:
        if (imem_ready) begin
          if (!flag)
            next_st = S_FETCH;
          else if (cls == CLS_UND) begin
            und_hit = TRAP_EN;
            next_st = TRAP_EN ? S_TRAP : S_FETCH;
          end else if (cls == CLS_B)
            next_st = link ? S_BLNK : S_BADD;
          else
            next_st = S_DECODE;
        end
      S_DECODE:
        if (cls == CLS_BX)      next_st = S_BXW;
        else if (cls == CLS_LS) next_st = S_LSADDR;
        else                    next_st = S_EXEC;
      S_EXEC:   next_st = S_WB;
      S_WB:     next_st = S_FETCH;
      S_BXW:    next_st = S_FETCH;
      S_BADD:   next_st = S_BJMP;
      S_BLNK:   next_st = S_BJMP;
      S_BJMP:   next_st = link_pend ? S_BJMP : S_FETCH;
      S_LSADDR: next_st = l_bit ? S_LDWAIT : S_STWAIT;
      S_LDWAIT, S_STWAIT:
        if (dmem_ready)
          next_st = (st == S_LDWAIT) ? S_LDWB : S_FETCH;
        else if (wait_inc == CW'(WAIT_LIMIT)) begin
          timeout = 1'b1;
          next_st = TRAP_EN ? S_TRAP : S_FETCH;
        end
      S_LDWB:   next_st = S_FETCH;
      S_TRAP:   next_st = S_FETCH;
      default:  next_st = S_IDLE;
    endcase
  end

  // State, wait counter and BL link-pass tracking
  always_ff @(posedge clk) begin
    if (Rst) begin
      st        <= S_IDLE;
      wait_cnt  <= '0;
      link_pend <= 1'b0;
    end else begin
      st        <= next_st;
      wait_cnt  <= ((st == S_LDWAIT || st == S_STWAIT) && next_st == st) ? wait_inc : '0;
      link_pend <= (st == S_BLNK);
    end
  end

  // Registered strobes decoded from the state being entered; ALU_OP and shifter selects hold
  always_ff @(posedge clk) begin
    if (Rst) begin
      fetch_q <= 1'b0; wpc_q <= 1'b0; Write_Reg <= 1'b0;
      LA <= 1'b0; LB <= 1'b0; LC <= 1'b0; LF <= 1'b0; S <= 1'b0;
      rm_imm_s <= 1'b0; rs_imm_s <= 2'b00; PC_s <= PCS_NEXT;
      rd_s <= 1'b0; ALU_A_s <= 1'b0; ALU_B_s <= 1'b0; off_s <= 1'b0; wb_s <= 1'b0;
      ALU_OP <= '0; dmem_req <= 1'b0; dmem_we <= 1'b0; und_trap <= 1'b0; abort <= 1'b0;
    end else begin
      fetch_q <= 1'b0; wpc_q <= 1'b0; Write_Reg <= 1'b0;
      LA <= 1'b0; LB <= 1'b0; LC <= 1'b0; LF <= 1'b0; S <= 1'b0;
      PC_s <= PCS_NEXT;
      rd_s <= 1'b0; ALU_A_s <= 1'b0; ALU_B_s <= 1'b0; off_s <= 1'b0; wb_s <= 1'b0;
      dmem_req <= 1'b0; dmem_we <= 1'b0;
      und_trap <= und_hit;
      abort    <= timeout;
      case (next_st)
        S_FETCH:  fetch_q <= 1'b1;
        S_DECODE: begin LA <= 1'b1; LB <= 1'b1; LC <= 1'b1; end
        S_EXEC: begin
          LF       <= 1'b1;
          S        <= s_bit;
          rm_imm_s <= (cls == CLS_DP2);
          rs_imm_s <= (cls == CLS_DP1) ? 2'b01 : (cls == CLS_DP2) ? 2'b10 : 2'b00;
          ALU_OP   <= alu_map(op);
        end
        S_WB:  Write_Reg <= !op[3] | op[2];
        S_BXW: begin wpc_q <= 1'b1; PC_s <= PCS_RM; end
        S_BADD: begin ALU_A_s <= 1'b1; ALU_B_s <= 1'b1; ALU_OP <= ALU_ADD; LF <= 1'b1; end
        S_BLNK: begin ALU_A_s <= 1'b1; ALU_OP <= ALU_MOV; LF <= 1'b1; end
        S_BJMP:
          // First pass after BLNK writes the link and re-latches F with the target
          if (st == S_BLNK) begin
            Write_Reg <= 1'b1; rd_s <= 1'b1;
            ALU_A_s <= 1'b1; ALU_B_s <= 1'b1; ALU_OP <= ALU_ADD; LF <= 1'b1;
          end else begin
            wpc_q <= 1'b1; PC_s <= PCS_F;
          end
        S_LSADDR: begin off_s <= 1'b1; LF <= 1'b1; ALU_OP <= u_bit ? ALU_ADD : ALU_SUB; end
        S_LDWAIT: dmem_req <= 1'b1;
        S_STWAIT: begin dmem_req <= 1'b1; dmem_we <= 1'b1; end
        S_LDWB:   begin Write_Reg <= 1'b1; wb_s <= 1'b1; end
        S_TRAP:   begin wpc_q <= 1'b1; PC_s <= PCS_TRAP; end
        default: ;
      endcase
    end
  end

  // Fetch strobes qualify the registered FETCH flag with the ready arriving this cycle
  assign imem_req = fetch_q;
  assign Write_IR = fetch_q & imem_ready;
  assign Write_PC = wpc_q | (fetch_q & imem_ready);

endmodule

// File: tb/tb_arm_mc_ctrl_ls.sv
// Directed bench for arm_mc_ctrl_ls: one trapping and one non-trapping instance share stimulus.
module tb_arm_mc_ctrl_ls;

  logic clk = 1'b0;
  logic Rst, flag, imem_ready, dmem_ready;
  logic [31:0] IR;

  logic a_wpc, a_wir, a_wreg, a_la, a_lb, a_lc, a_lf, a_s, a_rm, a_rd, a_aa, a_ab;
  logic a_off, a_wb, a_ireq, a_dreq, a_dwe, a_und, a_abt;
  logic [1:0] a_rs, a_pcs;
  logic [3:0] a_op;
  logic b_wpc, b_wir, b_wreg, b_la, b_lb, b_lc, b_lf, b_s, b_rm, b_rd, b_aa, b_ab;
  logic b_off, b_wb, b_ireq, b_dreq, b_dwe, b_und, b_abt;
  logic [1:0] b_rs, b_pcs;
  logic [3:0] b_op;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [17:0] WPC  = 18'h20000, WIR = 18'h10000, WREG = 18'h08000;
  localparam logic [17:0] LA_  = 18'h04000, LB_ = 18'h02000, LC_  = 18'h01000;
  localparam logic [17:0] LF_  = 18'h00800, S_  = 18'h00400, RDS  = 18'h00200;
  localparam logic [17:0] AA   = 18'h00100, AB  = 18'h00080, OFF  = 18'h00040;
  localparam logic [17:0] WBS  = 18'h00020, IRQ = 18'h00010, DRQ  = 18'h00008;
  localparam logic [17:0] DWE  = 18'h00004, UND = 18'h00002, ABT  = 18'h00001;
  localparam logic [17:0] FET  = WPC | WIR | IRQ;
  localparam logic [17:0] DEC  = LA_ | LB_ | LC_;

  localparam logic [31:0] I_ADD = 32'hE0821003, I_CMP = 32'hE3510005, I_BL  = 32'hEB000002;
  localparam logic [31:0] I_BX  = 32'hE12FFF11, I_B   = 32'hEA000002, I_LDR = 32'hE5910008;
  localparam logic [31:0] I_STR = 32'hE5810008, I_UND = 32'hE7F000F0;

  logic [23:0] a_obs, b_obs;
  assign a_obs = {a_wpc, a_wir, a_wreg, a_la, a_lb, a_lc, a_lf, a_s, a_rd, a_aa, a_ab,
                  a_off, a_wb, a_ireq, a_dreq, a_dwe, a_und, a_abt, a_pcs, a_op};
  assign b_obs = {b_wpc, b_wir, b_wreg, b_la, b_lb, b_lc, b_lf, b_s, b_rd, b_aa, b_ab,
                  b_off, b_wb, b_ireq, b_dreq, b_dwe, b_und, b_abt, b_pcs, b_op};

  arm_mc_ctrl_ls #(.WAIT_LIMIT(4), .TRAP_EN(1'b1)) dut (
    .clk(clk), .Rst(Rst), .IR(IR), .flag(flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .Write_PC(a_wpc), .Write_IR(a_wir), .Write_Reg(a_wreg), .LA(a_la), .LB(a_lb), .LC(a_lc),
    .LF(a_lf), .S(a_s), .rm_imm_s(a_rm), .rs_imm_s(a_rs), .PC_s(a_pcs), .rd_s(a_rd),
    .ALU_A_s(a_aa), .ALU_B_s(a_ab), .off_s(a_off), .wb_s(a_wb), .ALU_OP(a_op),
    .imem_req(a_ireq), .dmem_req(a_dreq), .dmem_we(a_dwe), .und_trap(a_und), .abort(a_abt)
  );

  arm_mc_ctrl_ls #(.WAIT_LIMIT(4), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .Rst(Rst), .IR(IR), .flag(flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .Write_PC(b_wpc), .Write_IR(b_wir), .Write_Reg(b_wreg), .LA(b_la), .LB(b_lb), .LC(b_lc),
    .LF(b_lf), .S(b_s), .rm_imm_s(b_rm), .rs_imm_s(b_rs), .PC_s(b_pcs), .rd_s(b_rd),
    .ALU_A_s(b_aa), .ALU_B_s(b_ab), .off_s(b_off), .wb_s(b_wb), .ALU_OP(b_op),
    .imem_req(b_ireq), .dmem_req(b_dreq), .dmem_we(b_dwe), .und_trap(b_und), .abort(b_abt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; IR = '0; flag = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    tick(); tick();
    chk("reset_a", a_obs, '0);
    chk("reset_b", b_obs, '0);
    Rst = 1'b0; imem_ready = 1'b1; flag = 1'b1; IR = I_ADD;

    tick(); chk("add_fetch",  a_obs, {FET, 2'b00, 4'h0});
    tick(); chk("add_decode", a_obs, {DEC, 2'b00, 4'h0});
    tick(); chk("add_exec",   a_obs, {LF_, 2'b00, 4'h4});
            chk("add_shsel",  {21'd0, a_rm, a_rs}, 24'h000000);
    tick(); chk("add_wb",     a_obs, {WREG, 2'b00, 4'h4});
    tick(); chk("add_refetch", a_obs, {FET, 2'b00, 4'h4});
    IR = I_CMP;
    tick(); chk("cmp_decode", a_obs, {DEC, 2'b00, 4'h4});
    tick(); chk("cmp_exec",   a_obs, {LF_ | S_, 2'b00, 4'h2});
            chk("cmp_shsel",  {21'd0, a_rm, a_rs}, 24'h000006);
    tick(); chk("cmp_wb",     a_obs, {18'd0, 2'b00, 4'h2});
    tick(); chk("cmp_refetch", a_obs, {FET, 2'b00, 4'h2});
    IR = I_BL;
    tick(); chk("bl_blnk",    a_obs, {AA | LF_, 2'b00, 4'h8});
    tick(); chk("bl_link",    a_obs, {WREG | RDS | AA | AB | LF_, 2'b00, 4'h4});
    tick(); chk("bl_jmp",     a_obs, {WPC, 2'b10, 4'h4});
    tick(); chk("bl_refetch", a_obs, {FET, 2'b00, 4'h4});
    IR = I_BX;
    tick(); chk("bx_decode",  a_obs, {DEC, 2'b00, 4'h4});
    tick(); chk("bx_bxw",     a_obs, {WPC, 2'b01, 4'h4});
    tick(); chk("bx_refetch", a_obs, {FET, 2'b00, 4'h4});
    IR = I_B;
    tick(); chk("b_badd",     a_obs, {AA | AB | LF_, 2'b00, 4'h4});
    tick(); chk("b_jmp",      a_obs, {WPC, 2'b10, 4'h4});
    tick(); chk("b_refetch",  a_obs, {FET, 2'b00, 4'h4});
    IR = I_LDR;
    tick(); chk("ldr_decode", a_obs, {DEC, 2'b00, 4'h4});
    tick(); chk("ldr_addr",   a_obs, {OFF | LF_, 2'b00, 4'h4});
    tick(); chk("ldr_wait1",  a_obs, {DRQ, 2'b00, 4'h4});
    tick(); chk("ldr_wait2",  a_obs, {DRQ, 2'b00, 4'h4});
    tick(); chk("ldr_wait3",  a_obs, {DRQ, 2'b00, 4'h4});
    dmem_ready = 1'b1;
    tick(); chk("ldr_wb",     a_obs, {WREG | WBS, 2'b00, 4'h4});
    dmem_ready = 1'b0;
    tick(); chk("ldr_refetch", a_obs, {FET, 2'b00, 4'h4});
    IR = I_STR;
    tick(); chk("str_decode", a_obs, {DEC, 2'b00, 4'h4});
    tick(); chk("str_addr",   a_obs, {OFF | LF_, 2'b00, 4'h4});
    for (int i = 0; i < 4; i++) begin
      tick(); chk("str_wait", a_obs, {DRQ | DWE, 2'b00, 4'h4});
    end
    tick(); chk("str_abort_trap",   a_obs, {WPC | ABT, 2'b11, 4'h4});
            chk("str_abort_notrap", b_obs, {FET | ABT, 2'b00, 4'h4});
    tick(); chk("trap_refetch", a_obs, {FET, 2'b00, 4'h4});

    Rst = 1'b1;
    tick(); chk("realign_rst_a", a_obs, '0);
            chk("realign_rst_b", b_obs, '0);
    Rst = 1'b0; IR = I_ADD; flag = 1'b0;
    tick(); chk("nc_fetch",   a_obs, {FET, 2'b00, 4'h0});
    tick(); chk("nc_refetch", a_obs, {FET, 2'b00, 4'h0});
            chk("nc_refetch_b", b_obs, {FET, 2'b00, 4'h0});
    IR = I_UND; flag = 1'b1;
    tick(); chk("und_trap",   a_obs, {WPC | UND, 2'b11, 4'h0});
            chk("und_skip_b", b_obs, {FET, 2'b00, 4'h0});
    tick(); chk("und_refetch", a_obs, {FET, 2'b00, 4'h0});
    IR = I_LDR;
    tick(); chk("ldr2_decode", a_obs, {DEC, 2'b00, 4'h0});
    tick(); chk("ldr2_addr",   a_obs, {OFF | LF_, 2'b00, 4'h4});
    tick(); chk("ldr2_wait",   a_obs, {DRQ, 2'b00, 4'h4});
    Rst = 1'b1; dmem_ready = 1'b1;
    tick(); chk("rst_in_wait_a", a_obs, '0);
            chk("rst_in_wait_b", b_obs, '0);
    tick(); chk("rst_hold", a_obs, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
